// File: rtl/dac_serial_pkg.sv
// rtl/dac_serial_pkg.sv - shared types and constants for the SPI DAC frame writer
package dac_serial_pkg;

    localparam int FRAME_W = 32;
    localparam int DATA_W  = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCK_LO = 2'd1,
        SCK_HI = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [3:0] CMD_WRITE        = 4'b0000;
    localparam logic [3:0] CMD_UPDATE       = 4'b0001;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;
    localparam logic [3:0] ADDR_ALL         = 4'b1111;

    // DAC frame: eight don't-care zeros, command, address, code, four padding zeros
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [3:0]        cmd,
        input logic [3:0]        addr,
        input logic [DATA_W-1:0] data
    );
        return {8'h00, cmd, addr, data, 4'h0};
    endfunction

endpackage

// File: rtl/dac_serial_writer_sck_phase_timer.sv
// rtl/dac_serial_writer_sck_phase_timer.sv - SCK half-period down-counter with terminal-count tick
module sck_phase_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic phase_tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] count;

    // Reload at frame start and at every terminal count, so each phase lasts CLK_DIV cycles
    always_ff @(posedge clk_in) begin
        if (reset) begin
            count <= RELOAD;
        end else if (load) begin
            count <= RELOAD;
        end else if (enable) begin
            count <= (count == 8'd0) ? RELOAD : count - 8'd1;
        end
    end

    assign phase_tick = enable && (count == 8'd0);

endmodule

// File: rtl/dac_serial_writer.sv
// rtl/dac_serial_writer.sv - SPI frame transmitter for an LTC2624-style DAC; DAC_ECHO_EN adds SDO capture
module dac_serial_writer
    import dac_serial_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        cmd,
    input  logic [3:0]        addr,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic              dac_cs_n
`ifdef DAC_ECHO_EN
    ,
    input  logic              spi_miso,
    output logic [FRAME_W-1:0] echo
`endif
);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("dac_serial_writer: CLK_DIV must be within 1..255");
    end

    state_t               state, state_nx;
    logic [FRAME_W-1:0]   shift_reg, shift_nx;
    logic [5:0]           bit_cnt, bit_cnt_nx;
    logic                 start_old;
    logic                 sck_nx, cs_n_nx, busy_nx, done_nx;
    logic                 start_edge;
    logic                 phase_tick;
    logic [FRAME_W-1:0]   frame_in;

    assign frame_in   = build_frame(cmd, addr, data);
    assign start_edge = (state == IDLE) && !start_old && start;
    // MOSI is the MSB of the shift register, so it only moves when the register shifts
    assign spi_mosi   = shift_reg[FRAME_W-1];

    sck_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clk_in     (clk_in),
        .reset      (reset),
        .load       (start_edge),
        .enable     (state != IDLE),
        .phase_tick (phase_tick)
    );

    // State and output registers; start_old resets high so a held start cannot fire
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state     <= IDLE;
            start_old <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
            spi_sck   <= 1'b0;
            dac_cs_n  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            start_old <= start;
            shift_reg <= shift_nx;
            bit_cnt   <= bit_cnt_nx;
            spi_sck   <= sck_nx;
            dac_cs_n  <= cs_n_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_nx   = state;
        shift_nx   = shift_reg;
        bit_cnt_nx = bit_cnt;
        sck_nx     = spi_sck;
        cs_n_nx    = dac_cs_n;
        busy_nx    = busy;
        done_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nx   = SCK_LO;
                    shift_nx   = frame_in;
                    bit_cnt_nx = 6'(FRAME_W - 1);
                    sck_nx     = 1'b0;
                    cs_n_nx    = 1'b0;
                    busy_nx    = 1'b1;
                end
            end
            SCK_LO: begin
                if (phase_tick) begin
                    sck_nx   = 1'b1;
                    state_nx = SCK_HI;
                end
            end
            SCK_HI: begin
                if (phase_tick) begin
                    sck_nx = 1'b0;
                    if (bit_cnt != 6'd0) begin
                        shift_nx   = {shift_reg[FRAME_W-2:0], 1'b0};
                        bit_cnt_nx = bit_cnt - 6'd1;
                        state_nx   = SCK_LO;
                    end else begin
                        shift_nx = '0;
                        cs_n_nx  = 1'b1;
                        done_nx  = 1'b1;
                        state_nx = GAP;
                    end
                end
            end
            GAP: begin
                if (phase_tick) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: ;
        endcase
    end

`ifdef DAC_ECHO_EN
    logic [FRAME_W-1:0] rx_shift;

    // Sample SDO on each SCK rising cycle; publish the word when the frame completes
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rx_shift <= '0;
            echo     <= '0;
        end else begin
            if (state == SCK_LO && phase_tick) begin
                rx_shift <= {rx_shift[FRAME_W-2:0], spi_miso};
            end
            if (done_nx) begin
                echo <= rx_shift;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dac_serial_writer.sv
// tb/tb_dac_serial_writer.sv - randomized self-checking bench for dac_serial_writer at CLK_DIV 2, 1 and 5
module tb_dac_serial_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b1;
    logic [3:0]  cmd = '0;
    logic [3:0]  addr = '0;
    logic [11:0] data = '0;
    longint      cyc = 0;
    longint      cur_cyc;
    int          errors = 0;
    int          checks = 0;
    int          divs [3] = '{2, 1, 5};

    int          frames_a [3], rises_a [3], busy_len_a [3], cs_len_a [3];
    int          done_cnt_a [3], viol_a [3], mism_a [3];
    longint      done_off_a [3];
    logic [31:0] rx_a [3];
    logic        cs_a [3], sck_a [3], busy_a [3], mosi_a [3], done_a [3];
    int          base_frames [3], base_rises [3], base_done [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    assign cur_cyc = cyc - 1;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_inst
        localparam int DIV = (k == 0) ? 2 : ((k == 1) ? 1 : 5);
        logic sck, mosi, cs_n, busy, done;
`ifdef DAC_ECHO_EN
        logic        miso = 1'b0;
        logic [31:0] echo;
        logic [31:0] pat = 32'hDEADBEEF;
`endif

        dac_serial_writer #(.CLK_DIV(DIV)) u_dut (
            .clk_in   (clk),
            .reset    (reset),
            .start    (start),
            .cmd      (cmd),
            .addr     (addr),
            .data     (data),
            .busy     (busy),
            .done     (done),
            .spi_sck  (sck),
            .spi_mosi (mosi),
            .dac_cs_n (cs_n)
`ifdef DAC_ECHO_EN
            ,
            .spi_miso (miso),
            .echo     (echo)
`endif
        );

        // Reference model: a frame is a time window starting at the accepted edge
        logic        armed = 1'b0, m_active = 1'b0, m_prev = 1'b1;
        longint      m_t0 = 0;
        logic [31:0] m_word = '0;
        always @(posedge clk) begin
            if (reset) begin
                armed    <= 1'b1;
                m_active <= 1'b0;
                m_prev   <= 1'b1;
            end else begin
                m_prev <= start;
                if (start && !m_prev && (!m_active || cyc > m_t0 + 65 * DIV)) begin
                    m_active <= 1'b1;
                    m_t0     <= cyc;
                    m_word   <= {8'h00, cmd, addr, data, 4'h0};
                end
            end
        end

        longint off;
        logic   e_in, e_busy, e_cs_n, e_done, e_sck, e_mosi;
        always_comb begin
            off    = cur_cyc - m_t0;
            e_in   = m_active && off >= 0 && off < 64 * DIV;
            e_busy = m_active && off >= 0 && off < 65 * DIV;
            e_cs_n = !e_in;
            e_done = m_active && off == 64 * DIV;
            e_sck  = e_in && ((off / DIV) % 2 == 1);
            e_mosi = e_in ? m_word[5'(31 - off / (2 * DIV))] : 1'b0;
        end

        // Observed-waveform statistics
        logic        p_sck = 1'b0, p_mosi = 1'b0, p_busy = 1'b0, p_cs_n = 1'b1;
        logic        rise_now, chg_now, csfall_now;
        int          rises = 0, frames = 0, done_cnt = 0, busy_run = 0, busy_len = 0;
        int          cs_run = 0, cs_len = 0, viol = 0, mism = 0, rif = 0, n_next;
        longint      t_rise = 0, done_off = 0, last_rise = -1000, last_chg = -1000;
        logic [31:0] rx = '0;

        always_comb begin
            rise_now   = sck && !p_sck;
            chg_now    = (mosi != p_mosi);
            csfall_now = !cs_n && p_cs_n;
            n_next     = csfall_now ? 0 : rif + (rise_now ? 1 : 0);
        end

        always @(negedge clk) begin
            if (armed) begin
                p_sck  <= sck;
                p_mosi <= mosi;
                p_busy <= busy;
                p_cs_n <= cs_n;
                if (rise_now) begin
                    rx        <= {rx[30:0], mosi};
                    rises     <= rises + 1;
                    last_rise <= cur_cyc;
                end
                if (chg_now) last_chg <= cur_cyc;
                viol <= viol + ((rise_now && (cur_cyc - last_chg < DIV)) ? 1 : 0)
                             + ((chg_now && (sck || (cur_cyc - last_rise < DIV))) ? 1 : 0);
                rif <= n_next;
                if (busy && !p_busy) begin
                    frames   <= frames + 1;
                    busy_run <= 1;
                    t_rise   <= cur_cyc;
                end else if (busy) begin
                    busy_run <= busy_run + 1;
                end
                if (!busy && p_busy) busy_len <= busy_run;
                if (done) begin
                    done_cnt <= done_cnt + 1;
                    done_off <= cur_cyc - t_rise;
                end
                if (csfall_now) cs_run <= 1;
                else if (!cs_n) cs_run <= cs_run + 1;
                if (cs_n && !p_cs_n) cs_len <= cs_run;
                if ({busy, cs_n, done, sck, mosi} !== {e_busy, e_cs_n, e_done, e_sck, e_mosi})
                    mism <= mism + 1;
`ifdef DAC_ECHO_EN
                miso <= (n_next < 32) ? pat[5'(31 - n_next)] : 1'b0;
`endif
            end
        end

        assign frames_a[k]   = frames;
        assign rises_a[k]    = rises;
        assign busy_len_a[k] = busy_len;
        assign cs_len_a[k]   = cs_len;
        assign done_cnt_a[k] = done_cnt;
        assign done_off_a[k] = done_off;
        assign viol_a[k]     = viol;
        assign mism_a[k]     = mism;
        assign rx_a[k]       = rx;
        assign cs_a[k]       = cs_n;
        assign sck_a[k]      = sck;
        assign busy_a[k]     = busy;
        assign mosi_a[k]     = mosi;
        assign done_a[k]     = done;
    end

    task automatic snapshot();
        for (int k = 0; k < 3; k++) begin
            base_frames[k] = frames_a[k];
            base_rises[k]  = rises_a[k];
            base_done[k]   = done_cnt_a[k];
        end
    endtask

    initial begin
        logic [3:0]  c, a;
        logic [11:0] d;

        // Reset with start held high: outputs at reset values, no frame afterwards
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_cs_n[%0d]", k), cs_a[k], 1);
            check($sformatf("rst_sck[%0d]", k), sck_a[k], 0);
            check($sformatf("rst_mosi[%0d]", k), mosi_a[k], 0);
            check($sformatf("rst_busy[%0d]", k), busy_a[k], 0);
            check($sformatf("rst_done[%0d]", k), done_a[k], 0);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 3; k++) check($sformatf("held_start_no_frame[%0d]", k), frames_a[k], 0);

        // Directed frame 3/0/ABC, start held for 500 cycles, data scrambled after capture
        start = 1'b0;
        cmd   = 4'd3;
        addr  = 4'd0;
        data  = 12'hABC;
        snapshot();
        @(negedge clk);
        start = 1'b1;
        repeat (500) begin
            @(negedge clk);
            data = 12'($urandom);
        end
        check("busy_len_div2", busy_len_a[0], 130);
        check("done_off_div2", done_off_a[0], 128);
        check("cs_low_div2", cs_len_a[0], 128);
        check("busy_len_div1", busy_len_a[1], 65);
        check("busy_len_div5", busy_len_a[2], 325);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("one_frame[%0d]", k), frames_a[k] - base_frames[k], 1);
            check($sformatf("sck_rises[%0d]", k), rises_a[k] - base_rises[k], 32);
            check($sformatf("mosi_word[%0d]", k), rx_a[k], 32'h0030ABC0);
            check($sformatf("done_pulses[%0d]", k), done_cnt_a[k] - base_done[k], 1);
            check($sformatf("cs_low[%0d]", k), cs_len_a[k], 64 * divs[k]);
`ifdef DAC_ECHO_EN
            if (k == 0) check("echo_div2", g_inst[0].echo, 32'hDEADBEEF);
            if (k == 1) check("echo_div1", g_inst[1].echo, 32'hDEADBEEF);
            if (k == 2) check("echo_div5", g_inst[2].echo, 32'hDEADBEEF);
`endif
        end

        // Random frames with a second start edge 50 cycles in that must be ignored
        for (int i = 0; i < 4; i++) begin
            start = 1'b0;
            c = 4'($urandom_range(15));
            a = 4'($urandom_range(15));
            d = 12'($urandom);
            cmd  = c;
            addr = a;
            data = d;
            snapshot();
            @(negedge clk);
            start = 1'b1;
            repeat (50) @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            start = 1'b1;
            repeat (400) begin
                @(negedge clk);
                data = 12'($urandom);
            end
            for (int k = 0; k < 3; k++) begin
                check($sformatf("rand%0d_frames[%0d]", i, k), frames_a[k] - base_frames[k], 1);
                check($sformatf("rand%0d_word[%0d]", i, k), rx_a[k], {8'h00, c, a, d, 4'h0});
            end
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("setup_hold[%0d]", k), viol_a[k], 0);
            check($sformatf("model_trace[%0d]", k), mism_a[k], 0);
        end

        // Reset 40 cycles into a frame aborts it; start held through release gives no frame
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        repeat (40) @(negedge clk);
        snapshot();
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("abort_cs_n[%0d]", k), cs_a[k], 1);
            check($sformatf("abort_sck[%0d]", k), sck_a[k], 0);
            check($sformatf("abort_busy[%0d]", k), busy_a[k], 0);
        end
        reset = 1'b0;
        repeat (400) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("abort_no_done[%0d]", k), done_cnt_a[k] - base_done[k], 0);
            check($sformatf("abort_no_refire[%0d]", k), frames_a[k] - base_frames[k], 0);
            check($sformatf("abort_model_trace[%0d]", k), mism_a[k], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_serial_writer.md
Name: dac_serial_writer

Overview:
Serial transmitter feeding the external SPI DAC (LTC2624-style 32-bit frame) from the fabric's latched sample words. A rising edge on start captures cmd/addr/data and shifts one frame MSB-first. The block drives SCK, MOSI and CS_n directly and reports busy/done to the sequencing logic. It is the output-side counterpart of the edge-triggered capture latches.

Parameters:
CLK_DIV, 2, clk_in cycles per SCK half-period; legal range 1..255, and out-of-range values fail elaboration.
FRAME_W, 32, bits per frame; fixed by the DAC and not to be overridden.
DATA_W, 12, DAC code width.

Ports:
clk_in  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  frame request; a rising edge triggers a frame
cmd  in  4  DAC command nibble
addr  in  4  DAC channel address nibble
data  in  12  DAC code
busy  out  1  high from the trigger cycle through the CS-high gap
done  out  1  one-cycle pulse when CS_n returns high
spi_sck  out  1  serial clock, idles low
spi_mosi  out  1  serial data; changes only while SCK is low
dac_cs_n  out  1  chip select, active low

Behaviour:
- Clock and reset: clk_in, with reset synchronous and active-high. All outputs and state are registered.
- Reset values: spi_sck=0, spi_mosi=0, dac_cs_n=1, busy=0, done=0, state=IDLE, start_old=1. Because start_old resets to 1, a start held high through reset does not trigger a frame; a fresh rising edge is needed.
- Frame layout, MSB first: {8'h00, cmd, addr, data, 4'h0}.
- States: IDLE, SCK_LO, SCK_HI, GAP.
- IDLE to SCK_LO when start_old=0 and start=1 (edge cycle T0). At T0 the block:
  - captures the frame into the shift register,
  - sets dac_cs_n=0, busy=1, spi_mosi=frame[31], spi_sck=0,
  - sets the phase counter to CLK_DIV-1.
- SCK_LO: hold for CLK_DIV cycles, then spi_sck=1 and go to SCK_HI.
- SCK_HI: hold for CLK_DIV cycles, then spi_sck=0 and:
  - if bits remain: shift, put the next bit on spi_mosi in the same cycle, go to SCK_LO;
  - after bit 0: dac_cs_n=1, spi_mosi=0, done=1 for one cycle, go to GAP.
- GAP: hold for CLK_DIV cycles with busy=1, then busy=0 and go to IDLE.
- Timing:
  - SCK rises CLK_DIV cycles after each MOSI change, so setup time equals hold time equals CLK_DIV clocks.
  - busy is high for exactly 65*CLK_DIV cycles, 130 at the default.
  - done asserts 64*CLK_DIV cycles after T0.
- Start edges while busy=1 are ignored and not queued. start_old updates every cycle, so a start held high through the end of a frame does not retrigger.
- The bit counter is 6-bit and counts down from 31; it never wraps, because GAP is entered at 0.
- Inputs are sampled only at T0. Changes to cmd/addr/data mid-frame do not affect the frame in flight.
- Reset mid-frame aborts immediately to the reset values. The DAC discards the partial frame because CS_n rises before the 32nd SCK.

Optional Feature:
DAC_ECHO_EN.
- Defined:
  - adds input spi_miso (1 bit) and output echo (32 bits, reset 0);
  - spi_miso is sampled into a receive shift register on every SCK rising-edge cycle;
  - echo loads the received word in the done cycle, giving the previous frame as echoed by the DAC SDO.
- Undefined: no spi_miso/echo ports and no receive logic; behaviour is otherwise identical.

Decomposition:
- Package dac_serial_pkg:
  - state enum;
  - FRAME_W=32 and DATA_W=12;
  - command constants CMD_WRITE=4'b0000, CMD_UPDATE=4'b0001, CMD_WRITE_UPDATE=4'b0011, CMD_POWER_DOWN=4'b0100;
  - ADDR_ALL=4'b1111.
- Sub-module sck_phase_timer:
  - down-counter loaded with CLK_DIV-1;
  - emits a one-cycle phase_tick at terminal count and reloads;
  - enabled only outside IDLE.
- The FSM, shift register and edge detector stay in the top module.

Test Plan:
- CLK_DIV=2; cmd=3, addr=0, data=12'hABC; one start edge -> exactly 32 SCK rising edges, and the MOSI bits sampled at those edges are 32'h0030ABC0. busy is high for 130 cycles, done pulses once at T0+128, and dac_cs_n is low for cycles T0..T0+127.
- Start held high for 500 cycles -> exactly one frame. Start pulsed again at T0+50 -> ignored, no second frame. A new edge after busy falls -> second frame starts.
- Reset asserted at T0+40 -> next cycle dac_cs_n=1, spi_sck=0, busy=0, with no done pulse. Start kept high through reset release -> no frame.
- CLK_DIV=1 -> SCK period of 2 cycles, busy for 65 cycles. CLK_DIV=5 -> busy for 325 cycles. In both cases MOSI is stable for CLK_DIV cycles either side of every SCK rise.
- data changed every cycle mid-frame -> the shifted word equals the value captured at T0.
- DAC_ECHO_EN defined, spi_miso driven with the bit pattern 32'hDEADBEEF aligned to SCK rises -> echo=32'hDEADBEEF in the cycle after done.
